// File: rtl/serial_abs_negator.sv
// serial_abs_negator: bit-serial two's-complement sign unit for LSB-first words.
// Each WIDTH-bit word is passed, negated, made absolute or negative-absolute.
// The sign bit arrives last, so every word is replayed from a WIDTH-deep delay
// line through a serial complementer one word later. Ovf flags the case where
// the most-negative value is negated.
module serial_abs_negator #(
    parameter int WIDTH = 8
) (
    input  logic       CLK,
    input  logic       Reset_n,
    input  logic       En,
    input  logic       X,
    input  logic       Sync,
    input  logic [1:0] Mode,
    output logic       N,
    output logic       N_valid,
    output logic       N_last,
    output logic       Ovf
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    // Input side
    logic [CW-1:0]    r_cnt;
    logic [1:0]       r_mode_w;
    logic             r_zlow;
    logic [WIDTH-1:0] r_dl;

    // Output side
    logic             r_win;
    logic [CW-1:0]    r_wcnt;
    logic             r_seen;
    logic             r_neg;
    logic             r_ovfw;

    logic [CW-1:0]    w_idx;
    logic             w_first;
    logic             w_done;
    logic             w_neg;
    logic             w_ovf;
    logic             w_d;

    // Sync overrides the counter so the current bit becomes bit 0
    assign w_idx   = Sync ? '0 : r_cnt;
    assign w_first = (w_idx == '0);
    assign w_done  = (w_idx == LAST);
    assign w_d     = r_dl[WIDTH-1];
    assign w_ovf   = w_neg & X & r_zlow;

    // Negation decision at the completion bit, where X is the sign
    always_comb begin
        w_neg = 1'b0;
        case (r_mode_w)
            2'b00: w_neg = 1'b0;
            2'b01: w_neg = 1'b1;
            2'b10: w_neg = X;
            2'b11: w_neg = ~X;
            default: w_neg = 1'b0;
        endcase
    end

    // Bit counter, per-word mode latch, low-bits-zero tracker and delay line
    always_ff @(negedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_cnt    <= '0;
            r_mode_w <= 2'b00;
            r_zlow   <= 1'b0;
            r_dl     <= '0;
        end else if (En) begin
            r_cnt <= w_done ? '0 : w_idx + 1'b1;
            if (w_first) begin
                r_mode_w <= Mode;
                r_zlow   <= ~X;
            end else begin
                r_zlow   <= r_zlow & ~X;
            end
            r_dl <= {r_dl[WIDTH-2:0], X};
        end
    end

    // Serial complementer: copy bits up to and including the first 1, then
    // invert; a completion edge reloads the window so words chain seamlessly
    always_ff @(negedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_win   <= 1'b0;
            r_wcnt  <= '0;
            r_seen  <= 1'b0;
            r_neg   <= 1'b0;
            r_ovfw  <= 1'b0;
            N       <= 1'b0;
            N_valid <= 1'b0;
            N_last  <= 1'b0;
            Ovf     <= 1'b0;
        end else if (En) begin
            if (r_win) begin
                N       <= w_d ^ (r_neg & r_seen);
                N_valid <= 1'b1;
                N_last  <= (r_wcnt == LAST);
                Ovf     <= (r_wcnt == LAST) & r_ovfw;
            end else begin
                N       <= 1'b0;
                N_valid <= 1'b0;
                N_last  <= 1'b0;
                Ovf     <= 1'b0;
            end
            if (w_done) begin
                r_win  <= 1'b1;
                r_wcnt <= '0;
                r_seen <= 1'b0;
                r_neg  <= w_neg;
                r_ovfw <= w_ovf;
            end else if (r_win) begin
                r_wcnt <= r_wcnt + 1'b1;
                r_seen <= r_seen | w_d;
                if (r_wcnt == LAST)
                    r_win <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_serial_abs_negator.sv
// Bench for serial_abs_negator: words go into an expected queue as they are
// driven; a monitor reassembles output words and each test pops and compares.
module tb_serial_abs_negator;
    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       Reset_n = 1'b0;
    logic       En = 1'b0;
    logic       X = 1'b0;
    logic       Sync = 1'b0;
    logic [1:0] Mode = 2'b00;
    logic       N, N_valid, N_last, Ovf;

    serial_abs_negator #(.WIDTH(W)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .En(En), .X(X), .Sync(Sync), .Mode(Mode),
        .N(N), .N_valid(N_valid), .N_last(N_last), .Ovf(Ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct { logic [7:0] w; logic ovf; } exp_t;
    typedef struct { logic [7:0] w; logic ovf; logic bad; int run; } obs_t;

    exp_t exp_q[$];
    obs_t obs_q[$];
    int checks = 0;
    int errors = 0;
    int mon_stray = 0;

    // outputs observed at the latest posedge, the previous one, and En of that edge
    logic o_v = 0, o_n = 0, o_l = 0, o_o = 0, o_en = 0;
    logic p_v = 0, p_n = 0, p_l = 0, p_o = 0;

    function automatic exp_t model(input logic [7:0] w, input logic [1:0] m);
        exp_t  e;
        logic  neg;
        case (m)
            2'b00: neg = 1'b0;
            2'b01: neg = 1'b1;
            2'b10: neg = w[7];
            default: neg = ~w[7];
        endcase
        e.w   = neg ? 8'(~w + 8'd1) : w;
        e.ovf = neg && (w == 8'h80);
        return e;
    endfunction

    // Monitor: collects completed output words after every enabled edge
    initial begin
        logic       en_edge;
        logic [7:0] mw;
        int         mc, run;
        logic       mbad;
        obs_t       o;
        mw = 0; mc = 0; run = 0; mbad = 0;
        forever begin
            @(negedge CLK);
            en_edge = En;
            @(posedge CLK);
            if (en_edge && Reset_n) begin
                if (N_valid) begin
                    run++;
                    if (mc < W) mw[mc] = N;
                    if (Ovf && !N_last) mbad = 1;
                    if (N_last) begin
                        if (mc != W-1) mbad = 1;
                        o.w = mw; o.ovf = Ovf; o.bad = mbad; o.run = run;
                        obs_q.push_back(o);
                        mc = 0; mw = 0; mbad = 0;
                    end else begin
                        mc++;
                    end
                end else begin
                    if (N || N_last || Ovf) mon_stray++;
                    mc = 0; mw = 0; mbad = 0; run = 0;
                end
            end
        end
    end

    task automatic drive_edge(input logic en, input logic sync, input logic x, input logic [1:0] mode);
        p_v = o_v; p_n = o_n; p_l = o_l; p_o = o_o;
        @(posedge CLK);
        o_v = N_valid; o_n = N; o_l = N_last; o_o = Ovf; o_en = En;
        En = en; Sync = sync; X = x; Mode = mode;
    endtask

    task automatic idle(input int n);
        repeat (n) drive_edge(1'b1, 1'b1, 1'b0, 2'b00);
    endtask

    // One word; optional random disabled edges and random mid-word Mode
    task automatic send_word(input logic [7:0] w, input logic [1:0] mode, input bit en_rand,
                             input bit push, input bit use_sync);
        for (int i = 0; i < W; i++) begin
            if (en_rand)
                while ($urandom_range(0, 1) == 0)
                    drive_edge(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
            drive_edge(1'b1, (i == 0) && use_sync, w[i], (i == 0) ? mode : 2'($urandom));
        end
        if (push) exp_q.push_back(model(w, mode));
    endtask

    task automatic test_reset();
        repeat (3) drive_edge(1'b1, 1'b0, 1'b1, 2'b01);
        checks++;
        if ({o_n, o_v, o_l, o_o} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs: got %b required 0000", {o_n, o_v, o_l, o_o});
        end
        drive_edge(1'b1, 1'b1, 1'b0, 2'b00);
        #1 Reset_n = 1'b1;
        idle(2);
    endtask

    task automatic test_negate();
        logic [7:0] w = 8'h05;
        logic [7:0] req = 8'hFB;
        for (int k = 0; k < 18; k++) begin
            if (k < W) drive_edge(1'b1, k == 0, w[k], (k == 0) ? 2'b01 : 2'b10);
            else idle(1);
            if (k >= 1) begin
                logic ev;
                ev = (k >= 9) && (k <= 16);
                checks++;
                if (o_v !== ev) begin
                    errors++; $display("FAIL negate_valid k=%0d: got %b required %b", k, o_v, ev);
                end
                if (ev) begin
                    checks++;
                    if (o_n !== req[k-9] || o_l !== (k == 16) || o_o !== 1'b0) begin
                        errors++;
                        $display("FAIL negate_bit k=%0d: got n=%b last=%b ovf=%b required n=%b last=%b ovf=0",
                                 k, o_n, o_l, o_o, req[k-9], k == 16);
                    end
                end
            end
        end
        exp_q.push_back(model(w, 2'b01));
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL negate_word: got none required %h", e.w);
            end else begin
                obs_t o = obs_q.pop_front();
                if (o.w !== e.w || o.ovf !== e.ovf || o.bad) begin
                    errors++; $display("FAIL negate_word: got %h ovf=%b bad=%b required %h ovf=%b", o.w, o.ovf, o.bad, e.w, e.ovf);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL negate_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_back_to_back();
        int idx = 0;
        send_word(8'hFD, 2'b10, 0, 1, 1);
        send_word(8'h07, 2'b10, 0, 1, 1);
        idle(12);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL b2b_word%0d: got none required %h", idx, e.w);
            end else begin
                obs_t o = obs_q.pop_front();
                if (o.w !== e.w || o.ovf !== e.ovf || o.bad) begin
                    errors++; $display("FAIL b2b_word%0d: got %h ovf=%b bad=%b required %h ovf=%b", idx, o.w, o.ovf, o.bad, e.w, e.ovf);
                end
                if (idx == 1) begin
                    checks++;
                    if (o.run != 2*W) begin
                        errors++; $display("FAIL b2b_contiguous: got %0d valid cycles required %0d", o.run, 2*W);
                    end
                end
            end
            idx++;
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL b2b_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_ovf();
        send_word(8'h80, 2'b01, 0, 1, 1);
        send_word(8'h80, 2'b00, 0, 1, 1);
        send_word(8'h80, 2'b11, 0, 1, 1);
        send_word(8'h00, 2'b01, 0, 1, 1);
        idle(12);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL ovf_word: got none required %h", e.w);
            end else begin
                obs_t o = obs_q.pop_front();
                if (o.w !== e.w || o.ovf !== e.ovf || o.bad) begin
                    errors++; $display("FAIL ovf_word: got %h ovf=%b bad=%b required %h ovf=%b", o.w, o.ovf, o.bad, e.w, e.ovf);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL ovf_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_enable();
        send_word(8'h01, 2'b01, 1, 1, 1);
        for (int i = 0; i < 60; i++) begin
            if (i < 45 && $urandom_range(0, 2) == 0)
                drive_edge(1'b0, 1'($urandom), 1'($urandom), 2'($urandom));
            else
                idle(1);
            if (!o_en) begin
                checks++;
                if ({o_n, o_v, o_l, o_o} !== {p_n, p_v, p_l, p_o}) begin
                    errors++; $display("FAIL enable_hold i=%0d: got %b required %b", i, {o_n, o_v, o_l, o_o}, {p_n, p_v, p_l, p_o});
                end
            end
        end
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL enable_word: got none required %h", e.w);
            end else begin
                obs_t o = obs_q.pop_front();
                if (o.w !== e.w || o.ovf !== e.ovf || o.bad) begin
                    errors++; $display("FAIL enable_word: got %h ovf=%b bad=%b required %h ovf=%b", o.w, o.ovf, o.bad, e.w, e.ovf);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL enable_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_abort();
        drive_edge(1'b1, 1'b1, 1'b1, 2'b01);
        drive_edge(1'b1, 1'b0, 1'b1, 2'b01);
        drive_edge(1'b1, 1'b0, 1'b1, 2'b01);
        send_word(8'h10, 2'b11, 0, 1, 1);
        idle(12);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL abort_word: got none required %h", e.w);
            end else begin
                obs_t o = obs_q.pop_front();
                if (o.w !== e.w || o.ovf !== e.ovf || o.bad || o.run != W) begin
                    errors++; $display("FAIL abort_word: got %h ovf=%b bad=%b run=%0d required %h ovf=%b run=%0d", o.w, o.ovf, o.bad, o.run, e.w, e.ovf, W);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL abort_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    task automatic test_async_reset();
        send_word(8'h55, 2'b01, 0, 0, 1);
        idle(4);
        checks++;
        if (o_v !== 1'b1) begin
            errors++; $display("FAIL areset_window: got valid=%b required 1", o_v);
        end
        #2 Reset_n = 1'b0;
        En = 1'b0;
        #1;
        checks++;
        if ({N, N_valid, N_last, Ovf} !== 4'b0000) begin
            errors++; $display("FAIL areset_immediate: got %b required 0000", {N, N_valid, N_last, Ovf});
        end
        #1 Reset_n = 1'b1;
        drive_edge(1'b0, 1'b0, 1'b0, 2'b00);
        send_word(8'h02, 2'b01, 0, 1, 0);
        idle(12);
        while (exp_q.size() > 0) begin
            exp_t e = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++; $display("FAIL areset_word: got none required %h", e.w);
            end else begin
                obs_t o = obs_q.pop_front();
                if (o.w !== e.w || o.ovf !== e.ovf || o.bad) begin
                    errors++; $display("FAIL areset_word: got %h ovf=%b bad=%b required %h ovf=%b", o.w, o.ovf, o.bad, e.w, e.ovf);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++; $display("FAIL areset_extra: got %0d extra words required 0", obs_q.size()); obs_q.delete();
        end
    endtask

    initial begin
        test_reset();
        test_negate();
        test_back_to_back();
        test_ovf();
        test_enable();
        test_abort();
        test_async_reset();
        checks++;
        if (mon_stray != 0) begin
            errors++; $display("FAIL idle_zero: got %0d nonzero outputs outside windows required 0", mon_stray);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule
